// File: rtl/alu_sched_pkg.sv
// Shared types, constants and word-building helpers for the ALU transaction scheduler.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package alu_sched_pkg;

    localparam int WORD_W   = 10;
    localparam int RSP_BITS = 30;
    localparam int MAX_OPS  = 7;

    typedef enum logic [7:0] {
        CMD_NOP = 8'h00,
        CMD_AND = 8'h01,
        CMD_OR  = 8'h02,
        CMD_XOR = 8'h03,
        CMD_ADD = 8'h10,
        CMD_SUB = 8'h20
    } operation_t;

    typedef enum logic [7:0] {
        S_NO_ERROR             = 8'h00,
        S_MISSING_DATA         = 8'h01,
        S_DATA_STACK_OVERFLOW  = 8'h02,
        S_OUTPUT_FIFO_OVERFLOW = 8'h04,
        S_DATA_PARITY_ERROR    = 8'h10,
        S_COMMAND_PARITY_ERROR = 8'h20,
        S_INVALID_COMMAND      = 8'h80
    } status_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        RESP
    } sched_state_t;

    // Control bit, payload, then the bit that makes the whole word XOR to 1.
    function automatic logic [WORD_W-1:0] mk_word(input logic ctl, input logic [7:0] b);
        return {ctl, b, ~(ctl ^ (^b))};
    endfunction

    // The DUT needs at least two operands; a 3-bit count cannot exceed MAX_OPS.
    function automatic logic [2:0] clamp_cnt(input logic [2:0] c);
        return (c < 3'd2) ? 3'd2 : c;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the rotating pointer.
// Latency: grant is combinational; pointer advances on the edge where upd is high.
// Backpressure: the pointer only moves when the caller accepts the grant (upd).
module alu_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             upd,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % N_REQ);
            if (req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // The requester after the winner gets top priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (upd && gnt_any) begin
            ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

endmodule

// File: rtl/alu_txn_sched.sv
// Serializes one arbitrated request at a time to the bit-serial ALU and returns its response.
// Latency: (cnt+1)*10 send + 1 + DUT wait + 30 receive + 1 cycles from grant.
// Backpressure: requesters hold req_valid until req_ready; responses are pulses with no stall.
module alu_txn_sched
    import alu_sched_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*8-1:0]       req_op,
    input  logic [N_REQ*3-1:0]       req_cnt,
    input  logic [N_REQ*56-1:0]      req_data,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [7:0]               rsp_status,
    output logic [15:0]              rsp_result,
    output logic [1:0]               rsp_err,
    output logic                     din,
    output logic                     enable_n,
    input  logic                     dout,
    input  logic                     dout_valid
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    sched_state_t          state;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic                  arb_upd;
    logic [IW-1:0]         owner;
    logic [N_REQ-1:0]      gnt_oh;
    logic [N_REQ-1:0]      owner_oh;
    logic [7:0]            op_q;
    logic [2:0]            cnt_q;
    logic [8*MAX_OPS-1:0]  data_q;
    logic [3:0]            word_idx;
    logic [3:0]            bit_pos;
    logic [WORD_W-1:0]     cur_word;
    logic                  send_done;
    logic [TW-1:0]         wait_cnt;
    logic [4:0]            rx_cnt;
    logic [RSP_BITS-2:0]   rx_sh;
    logic [RSP_BITS-1:0]   rx_full;
    logic                  par_err;

    alu_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .upd     (arb_upd),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign arb_upd  = (state == IDLE) && gnt_any;
    assign gnt_oh   = N_REQ'(1) << gnt_idx;
    assign owner_oh = N_REQ'(1) << owner;

    // Operand words come from the low byte of the shifting data copy; the last word is the command.
    always_comb begin
        cur_word = mk_word(1'b1, op_q);
        if (word_idx < {1'b0, cnt_q}) begin
            cur_word = mk_word(1'b0, data_q[7:0]);
        end
    end

    assign send_done = (word_idx == ({1'b0, cnt_q} + 4'd1));

    // Response bits arrive MSB first: status word, result high, result low.
    assign rx_full = {rx_sh, dout};
    assign par_err = (^rx_full[29:20]) | (^rx_full[19:10]) | (^rx_full[9:0]);

    // Scheduler FSM with all serial-port and response outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_status <= '0;
            rsp_result <= '0;
            rsp_err    <= '0;
            din        <= 1'b0;
            enable_n   <= 1'b1;
            owner      <= '0;
            op_q       <= '0;
            cnt_q      <= 3'd2;
            data_q     <= '0;
            word_idx   <= '0;
            bit_pos    <= '0;
            wait_cnt   <= '0;
            rx_cnt     <= '0;
            rx_sh      <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner     <= gnt_idx;
                        op_q      <= req_op[int'(gnt_idx)*8 +: 8];
                        cnt_q     <= clamp_cnt(req_cnt[int'(gnt_idx)*3 +: 3]);
                        data_q    <= req_data[int'(gnt_idx)*56 +: 56];
                        req_ready <= gnt_oh;
                        word_idx  <= '0;
                        bit_pos   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (send_done) begin
                        enable_n <= 1'b1;
                        din      <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end else begin
                        enable_n <= 1'b0;
                        din      <= cur_word[4'(WORD_W - 1) - bit_pos];
                        if (bit_pos == 4'(WORD_W - 1)) begin
                            bit_pos  <= '0;
                            word_idx <= word_idx + 4'd1;
                            if (word_idx < {1'b0, cnt_q}) begin
                                data_q <= data_q >> 8;
                            end
                        end else begin
                            bit_pos <= bit_pos + 4'd1;
                        end
                    end
                end
                WAIT: begin
                    if (dout_valid) begin
                        rx_sh  <= {{(RSP_BITS-2){1'b0}}, dout};
                        rx_cnt <= 5'd1;
                        state  <= RECV;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_status <= '0;
                        rsp_result <= '0;
                        rsp_err    <= 2'b10;
                        rsp_valid  <= owner_oh;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                RECV: begin
                    if (rx_cnt == 5'(RSP_BITS - 1)) begin
                        rsp_status <= rx_full[28:21];
                        rsp_result <= {rx_full[18:11], rx_full[8:1]};
                        rsp_err    <= {1'b0, par_err};
                        rsp_valid  <= owner_oh;
                        state      <= RESP;
                    end else begin
                        rx_sh  <= rx_full[RSP_BITS-2:0];
                        rx_cnt <= rx_cnt + 5'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_txn_sched.sv
// Randomized bench: behavioural requesters, a behavioural serial ALU model and a scoreboard.
// Latency: each transaction is waited for with a bounded cycle budget.
// Backpressure: requests are held until req_ready; responses are taken every cycle.
module tb_alu_txn_sched;
    import alu_sched_pkg::*;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  cnt;
        logic [55:0] data;
        int          mode;  // 0 normal, 1 model corrupts word1 parity, 2 model stays silent
    } txn_t;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*8-1:0]   req_op;
    logic [N_REQ*3-1:0]   req_cnt;
    logic [N_REQ*56-1:0]  req_data;
    logic [N_REQ-1:0]     rsp_valid;
    logic [7:0]           rsp_status;
    logic [15:0]          rsp_result;
    logic [1:0]           rsp_err;
    logic                 din;
    logic                 enable_n;
    logic                 dout;
    logic                 dout_valid;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   rsp_count = 0;
    int   rsp_cyc   = 0;
    int   frame_low = 0;
    int   frame_end_cyc = 0;
    logic [2:0] cur_cnt  = 3'd2;
    int   cur_mode = 0;
    txn_t pend0[$];
    txn_t pend1[$];
    txn_t exp0[$];
    txn_t exp1[$];
    int   grant_log[$];
    logic frame_bits[$];

    alu_txn_sched #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_cnt    (req_cnt),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .din        (din),
        .enable_n   (enable_n),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_cnt(input int c);
        return (c < 2) ? 2 : c;
    endfunction

    // Behavioural ALU: fold n operand bytes with the command.
    function automatic void ref_alu(input logic [7:0] op, input int n, input logic [55:0] d,
                                    output logic [7:0] st, output logic [15:0] res);
        logic [15:0] acc;
        st  = 8'h00;
        acc = 16'h0000;
        case (op)
            8'h10: for (int i = 0; i < n; i++) acc = acc + 16'(d[8*i +: 8]);
            8'h20: begin
                acc = 16'(d[7:0]);
                for (int i = 1; i < n; i++) acc = acc - 16'(d[8*i +: 8]);
            end
            8'h01: begin
                acc = 16'h00FF;
                for (int i = 0; i < n; i++) acc = acc & 16'(d[8*i +: 8]);
            end
            8'h02: for (int i = 0; i < n; i++) acc = acc | 16'(d[8*i +: 8]);
            8'h03: for (int i = 0; i < n; i++) acc = acc ^ 16'(d[8*i +: 8]);
            8'h00: acc = 16'h0000;
            default: begin
                st  = 8'h80;
                acc = 16'h0000;
            end
        endcase
        res = acc;
    endfunction

    task automatic push(input int r, input logic [7:0] op, input logic [2:0] cnt,
                        input logic [55:0] data, input int mode);
        txn_t t;
        t.op = op; t.cnt = cnt; t.data = data; t.mode = mode;
        if (r == 0) pend0.push_back(t);
        else        pend1.push_back(t);
    endtask

    task automatic wait_rsps(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (rsp_count < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(rsp_count >= target), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pend0.delete();
        pend1.delete();
        repeat (2) @(negedge clk);
        exp0.delete();
        exp1.delete();
        rst = 1'b0;
    endtask

    // Serial ALU model: collect a frame while enable_n is low, then answer it.
    initial begin : dut_model
        int          low;
        int          nw;
        bit          aborted;
        bit          len_err, dperr, cperr, ctl_err;
        logic [9:0]  wd;
        logic [7:0]  st, op_rx;
        logic [15:0] res;
        logic [55:0] dat_rx;
        logic [29:0] rb;
        logic [9:0]  w0, w1, w2;
        dout = 1'b0;
        dout_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!enable_n && !rst) begin
                low = 0; aborted = 0;
                frame_bits.delete();
                while (!enable_n && low < 200) begin
                    frame_bits.push_back(din);
                    if (rst) aborted = 1;
                    low++;
                    @(negedge clk);
                end
                if (rst) aborted = 1;
                frame_low     = low;
                frame_end_cyc = cyc;
                if (!aborted) begin
                    chk("frame_len", low, 32'((eff_cnt(int'(cur_cnt)) + 1) * 10));
                    nw = low / 10;
                    len_err = ((low % 10) != 0) || (nw < 2) || (nw > 8);
                    dperr = 0; cperr = 0; ctl_err = 0;
                    op_rx = 8'h00; dat_rx = '0;
                    if (!len_err) begin
                        for (int w = 0; w < nw; w++) begin
                            for (int j = 0; j < 10; j++) wd[9-j] = frame_bits[10*w + j];
                            if (w == nw - 1) begin
                                if (^wd != 1'b1) cperr = 1;
                                if (!wd[9]) ctl_err = 1;
                                op_rx = wd[8:1];
                            end else begin
                                if (^wd != 1'b1) dperr = 1;
                                if (wd[9]) ctl_err = 1;
                                dat_rx[8*w +: 8] = wd[8:1];
                            end
                        end
                    end
                    res = 16'h0000;
                    if (len_err)      st = 8'h01;
                    else if (dperr)   st = 8'h10;
                    else if (cperr)   st = 8'h20;
                    else if (ctl_err) st = 8'h01;
                    else ref_alu(op_rx, nw - 1, dat_rx, st, res);
                    w0 = {1'b0, st, ^st};
                    w1 = {1'b0, res[15:8], ^res[15:8]};
                    w2 = {1'b0, res[7:0], ^res[7:0]};
                    if (cur_mode == 1) w1[0] = ~w1[0];
                    rb = {w0, w1, w2};
                    if (cur_mode != 2) begin
                        repeat ($urandom_range(0, 4)) @(posedge clk);
                        for (int i = 0; i < 30; i++) begin
                            @(posedge clk);
                            #1;
                            dout       = rb[29-i];
                            dout_valid = (i == 0);
                        end
                        @(posedge clk);
                        #1;
                        dout = 1'b0;
                        dout_valid = 1'b0;
                    end
                end
            end
        end
    end

    // Requester side: record accepts, score responses, present queued requests.
    initial begin : req_side
        txn_t        t;
        logic [7:0]  st;
        logic [15:0] res;
        logic [1:0]  er;
        forever begin
            @(negedge clk);
            for (int r = 0; r < N_REQ; r++) begin
                if (req_ready[r]) begin
                    chk("ready_with_valid", 32'(req_valid[r]), 32'd1);
                    if (r == 0 && pend0.size() > 0) begin
                        t = pend0.pop_front(); exp0.push_back(t);
                    end else if (r == 1 && pend1.size() > 0) begin
                        t = pend1.pop_front(); exp1.push_back(t);
                    end
                    cur_cnt  = t.cnt;
                    cur_mode = t.mode;
                    grant_log.push_back(r);
                end
            end
            if (rsp_valid != '0) begin
                chk("rsp_onehot", 32'($countones(rsp_valid)), 32'd1);
                rsp_cyc = cyc;
                rsp_count++;
                for (int r = 0; r < N_REQ; r++) begin
                    if (rsp_valid[r]) begin
                        if ((r == 0 && exp0.size() == 0) || (r == 1 && exp1.size() == 0)) begin
                            chk("rsp_expected", 32'd0, 32'd1);
                        end else begin
                            t = (r == 0) ? exp0.pop_front() : exp1.pop_front();
                            if (t.mode == 2) begin
                                st = 8'h00; res = 16'h0000; er = 2'b10;
                            end else begin
                                ref_alu(t.op, eff_cnt(int'(t.cnt)), t.data, st, res);
                                er = (t.mode == 1) ? 2'b01 : 2'b00;
                            end
                            chk("rsp_status", 32'(rsp_status), 32'(st));
                            chk("rsp_result", 32'(rsp_result), 32'(res));
                            chk("rsp_err", 32'(rsp_err), 32'(er));
                        end
                    end
                end
            end
            req_valid[0] = (pend0.size() > 0);
            req_valid[1] = (pend1.size() > 0);
            for (int r = 0; r < N_REQ; r++) begin
                req_op[8*r +: 8]     = 8'($urandom());
                req_cnt[3*r +: 3]    = 3'($urandom());
                req_data[56*r +: 56] = {24'($urandom()), 32'($urandom())};
            end
            if (pend0.size() > 0) begin
                req_op[7:0] = pend0[0].op; req_cnt[2:0] = pend0[0].cnt; req_data[55:0] = pend0[0].data;
            end
            if (pend1.size() > 0) begin
                req_op[15:8] = pend1[0].op; req_cnt[5:3] = pend1[0].cnt; req_data[111:56] = pend1[0].data;
            end
        end
    end

    initial begin : main
        logic [9:0]  fw;
        logic [7:0]  ops [6];
        int          base;
        int          k;
        ops = '{8'h10, 8'h20, 8'h01, 8'h02, 8'h03, 8'hB3};
        rst = 1'b1;
        req_valid = '0; req_op = '0; req_cnt = '0; req_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_enable_n", 32'(enable_n), 32'd1);
        rst = 1'b0;

        // Single ADD 5+3.
        push(0, 8'h10, 3'd2, 56'h0305, 0);
        wait_rsps(1, 500, "add_done");
        chk("add_frame_len", frame_low, 32'd30);
        for (int j = 0; j < 10; j++) fw[9-j] = frame_bits[j];
        chk("add_first_word", 32'(fw), 32'b0000001011);
        chk("add_result", 32'(rsp_result), 32'h0008);
        chk("add_status", 32'(rsp_status), 32'h00);
        chk("add_err", 32'(rsp_err), 32'd0);

        // Contention straight after reset: grants alternate starting at 0.
        do_reset();
        grant_log.delete();
        base = rsp_count;
        for (int i = 0; i < 2; i++) begin
            push(0, 8'h10, 3'(2 + i), {24'($urandom()), 32'($urandom())}, 0);
            push(1, 8'h10, 3'(3 + i), {24'($urandom()), 32'($urandom())}, 0);
        end
        wait_rsps(base + 4, 2000, "contention_done");
        chk("grant_count", grant_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], 32'(i % 2));

        // Unknown command byte.
        base = rsp_count;
        push(0, 8'hB3, 3'd3, {24'($urandom()), 32'($urandom())}, 0);
        wait_rsps(base + 1, 500, "invalid_done");
        chk("invalid_status", 32'(rsp_status), 32'h80);
        chk("invalid_result", 32'(rsp_result), 32'h0000);
        chk("invalid_err", 32'(rsp_err), 32'd0);

        // Count clamps at both ends.
        base = rsp_count;
        push(1, 8'h10, 3'd0, 56'h0A09, 0);
        wait_rsps(base + 1, 500, "clamp_lo_done");
        chk("clamp_lo_len", frame_low, 32'd30);
        chk("clamp_lo_result", 32'(rsp_result), 32'h0013);
        push(0, 8'h10, 3'd7, 56'hFFFFFFFFFFFFFF, 0);
        wait_rsps(base + 2, 500, "clamp_hi_done");
        chk("clamp_hi_len", frame_low, 32'd80);
        chk("clamp_hi_result", 32'(rsp_result), 32'h06F9);

        // Corrupted response parity, then a silent DUT.
        base = rsp_count;
        push(0, 8'h03, 3'd4, {24'($urandom()), 32'($urandom())}, 1);
        wait_rsps(base + 1, 500, "parity_done");
        chk("parity_err", 32'(rsp_err), 32'b01);
        push(1, 8'h10, 3'd2, {24'($urandom()), 32'($urandom())}, 2);
        wait_rsps(base + 2, 500, "timeout_done");
        chk("timeout_err", 32'(rsp_err), 32'b10);
        chk("timeout_delay", rsp_cyc - frame_end_cyc, 32'(TIMEOUT));

        // Reset while bit 15 of a frame is on the wire.
        push(0, 8'h10, 3'd3, {24'($urandom()), 32'($urandom())}, 0);
        k = 0;
        while (enable_n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("abort_frame_started", 32'(enable_n), 32'd0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        pend0.delete();
        pend1.delete();
        @(negedge clk);
        chk("abort_enable_n", 32'(enable_n), 32'd1);
        @(negedge clk);
        exp0.delete();
        exp1.delete();
        rst = 1'b0;
        base = rsp_count;
        repeat (60) @(negedge clk);
        chk("abort_no_rsp", rsp_count, base);
        chk("abort_rsp_result", 32'(rsp_result), 32'd0);
        push(0, 8'h10, 3'd3, 56'h030201, 0);
        wait_rsps(base + 1, 500, "after_abort_done");
        chk("after_abort_result", 32'(rsp_result), 32'h0006);

        // Random mix on both requesters.
        base = rsp_count;
        for (int i = 0; i < 30; i++) begin
            push(int'($urandom_range(0, 1)), ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                 {24'($urandom()), 32'($urandom())}, 0);
        end
        wait_rsps(base + 30, 10000, "random_done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_txn_sched.md
Name: alu_txn_sched

Overview:
- Transaction scheduler between N_REQ parallel requesters and the shared bit-serial ALU (vdic_dut_2022).
- Arbitrates requests round-robin and serializes operand and command words onto din/enable_n.
- Waits for dout_valid, deserializes the 30-bit response, checks parity, and returns result/status to the granted requester.
- Sits directly in front of the DUT serial port; the DUT has no other drivers.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- TIMEOUT, 256, max cycles to wait for dout_valid after enable_n rises.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  request present, held until accepted.
- req_ready  out  N_REQ  one-cycle accept pulse to the granted requester.
- req_op  in  N_REQ*8  command byte per requester.
- req_cnt  in  N_REQ*3  operand count per requester.
- req_data  in  N_REQ*56  up to 7 operand bytes per requester; byte k at [8k+7:8k]; byte 0 is sent first.
- rsp_valid  out  N_REQ  one-cycle response pulse to the owning requester; no backpressure.
- rsp_status  out  8  DUT status byte.
- rsp_result  out  16  {hi byte, lo byte}.
- rsp_err  out  2  bit0 = response parity error, bit1 = timeout.
- din  out  1  serial data to DUT.
- enable_n  out  1  DUT frame enable, active low.
- dout  in  1  serial data from DUT.
- dout_valid  in  1  DUT response strobe.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: req_ready=0, rsp_valid=0, rsp_status=0, rsp_result=0, rsp_err=0, din=0, enable_n=1, FSM=IDLE, rr pointer=0.
- Reset mid-operation: frame aborted, enable_n=1 on the next edge, no rsp_valid. The requester must re-present.
- FSM IDLE:
  - Any req_valid → grant. Winner is the first valid index searching from (last_grant+1) mod N_REQ.
  - Latch op, data and count; pulse req_ready[g]; go to SEND.
- Count clamp: cnt<2 → 2; cnt>7 → 7.
- Word format, 10 bits, sent MSB first:
  - Operand word = {0, byte[7:0], p}.
  - Command word = {1, op[7:0], p}.
  - p is chosen so the XOR of all 10 bits = 1.
- SEND:
  - din/enable_n are registered; enable_n=0 for exactly (cnt+1)*10 consecutive cycles.
  - Bit order: operands 0..cnt-1, then the command word.
  - Next cycle: enable_n=1, din=0, go to WAIT.
- WAIT:
  - Counter runs from 0. dout_valid=1 → go to RECV and capture dout in that same cycle as bit 0.
  - Counter reaches TIMEOUT-1 → RESP with rsp_err=2'b10, status=0, result=0.
- RECV: shift in 30 bits total, one per cycle, regardless of dout_valid after the first.
  - Word0 = {start, status[7:0], par}.
  - Word1 = {start, result[15:8], par}.
  - Word2 = {start, result[7:0], par}.
  - rsp_err[0] = (^w0)|(^w1)|(^w2); each word must XOR to 0.
- RESP: drive rsp_valid[g]=1 for one cycle with the outputs valid; outputs hold until the next response. Then go to IDLE.
- req_valid dropped before grant: no effect. req changes after req_ready: ignored (latched copy used).
- Throughput: min gap between frames = 1 IDLE cycle. Never more than one outstanding transaction.
- Latency from grant: (cnt+1)*10 + 1 + wait + 30 + 1 cycles.

Decomposition:
- Package alu_sched_pkg:
  - operation_t (CMD_NOP, CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB).
  - status_t (S_NO_ERROR, S_MISSING_DATA, S_DATA_STACK_OVERFLOW, S_OUTPUT_FIFO_OVERFLOW, S_DATA_PARITY_ERROR, S_COMMAND_PARITY_ERROR, S_INVALID_COMMAND).
  - sched_state_t (IDLE, SEND, WAIT, RECV, RESP).
  - Constants WORD_W=10, RSP_BITS=30, MAX_OPS=7.
  - Function mk_word(ctl, byte) returning a parity-complete word.
- Sub-module alu_rr_arbiter: N_REQ round-robin, grant index plus update enable. Everything else is inline.

Test Plan:
- Single ADD: req0 op=0x10, cnt=2, data 0x05,0x03.
  - enable_n low 30 cycles.
  - First word on din = 0_00000101_1.
  - rsp_valid[0] with result=0x0008, status=0x00, err=0.
- Contention: req0 and req1 asserted in the same cycle after reset.
  - req0 granted first, then req1.
  - Both held continuously → grants alternate 0,1,0,1.
- Invalid command: op=0xB3, cnt=3 → status=0x80, result=0x0000, err=0.
- Clamp: cnt=0 → 2 operands sent (30 enable_n-low cycles); cnt=7 with 0xFF×7 ADD → result=0x06F9.
- Errors and timeout:
  - Bench-model DUT flips one bit in word1 → rsp_err=2'b01.
  - Model never raises dout_valid → rsp_err=2'b10 exactly TIMEOUT cycles after enable_n rises.
- Reset in SEND bit 15: enable_n=1 next cycle, no rsp_valid. A fresh request afterwards completes normally.
